dmem_arbiter: RTL and testbench

Two-port round-robin arbiter and access sequencer in front of the single-port byte-addressable data RAM. It shares the RAM between the CPU data port (m0) and a debug/DMA loader port (m1) and latches each request into a fixed three-phase transaction. It rejects misaligned, out-of-range or illegal-func3 accesses without touching memory, and returns registered load data with a one-cycle ready pulse.

---
 rtl/dmem_arbiter_if.sv | 15 +
 rtl/dmem_arbiter.sv | 95 +++++++++
 tb/tb_dmem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's bus into the data-RAM arbiter
//   req, we, addr, wdata, func3 : requester -> arbiter (hold req until ready)
//   ready, err, rdata           : arbiter -> requester (ready is a 1-cycle pulse)
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
    logic        ready;
    logic        err;
    logic [31:0] rdata;
    modport master (output req, we, addr, wdata, func3, input ready, err, rdata);
    modport slave  (input req, we, addr, wdata, func3, output ready, err, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter and IDLE/ACCESS/RESP sequencer for the data RAM
//   clk, reset      : clock, synchronous active-high reset
//   m0, m1          : requester buses (m0 = CPU, m1 = debug/DMA loader)
//   busy            : transaction in ACCESS or RESP
//   ram_we/addr/wData/func3 : RAM command, driven from the latched command register
//   ram_rData       : combinational RAM read data, already extended per func3
module dmem_arbiter #(
    parameter int MEM_BYTES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_arbiter_if.slave        m0,
    dmem_arbiter_if.slave        m1,
    output logic                 busy,
    output logic                 ram_we,
    output logic [31:0]          ram_addr,
    output logic [31:0]          ram_wData,
    output logic [2:0]           ram_func3,
    input  logic [31:0]          ram_rData
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      state;
    logic        cmd_we;
    logic        err_q;
    logic        owner;
    logic        last_gnt;
    logic        sel1;
    logic        n_we;
    logic        n_err;
    logic [31:0] n_addr;
    logic [31:0] n_wdata;
    logic [2:0]  n_f3;
    logic [31:0] rd;
    // on a tie the port that did not win last time is served
    assign sel1    = m1.req & (~m0.req | ~last_gnt);
    assign n_we    = sel1 ? m1.we    : m0.we;
    assign n_addr  = sel1 ? m1.addr  : m0.addr;
    assign n_wdata = sel1 ? m1.wdata : m0.wdata;
    assign n_f3    = sel1 ? m1.func3 : m0.func3;
    // f3[1:0]==11 covers 011/111; f3[2] on a store covers 100/101
    assign n_err = (n_addr >= 32'(MEM_BYTES)) | (n_f3[1:0] == 2'b11) | (n_f3 == 3'b110)
                 | (n_we & n_f3[2]) | ((n_f3[1:0] == 2'b01) & n_addr[0])
                 | ((n_f3[1:0] == 2'b10) & (n_addr[1:0] != 2'b00));
    assign rd     = (~cmd_we & ~err_q) ? ram_rData : 32'd0;
    assign busy   = state != IDLE;
    assign ram_we = (state == ACCESS) & cmd_we & ~err_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            owner     <= 1'b0;
            cmd_we    <= 1'b0;
            err_q     <= 1'b0;
            ram_addr  <= '0;
            ram_wData <= '0;
            ram_func3 <= '0;
            m0.ready  <= 1'b0;
            m0.err    <= 1'b0;
            m0.rdata  <= '0;
            m1.ready  <= 1'b0;
            m1.err    <= 1'b0;
            m1.rdata  <= '0;
        end else begin
            m0.ready <= 1'b0;
            m0.err   <= 1'b0;
            m1.ready <= 1'b0;
            m1.err   <= 1'b0;
            case (state)
                IDLE: if (m0.req | m1.req) begin
                    state     <= ACCESS;
                    owner     <= sel1;
                    last_gnt  <= sel1;
                    cmd_we    <= n_we;
                    err_q     <= n_err;
                    ram_addr  <= n_addr;
                    ram_wData <= n_wdata;
                    ram_func3 <= n_f3;
                end
                ACCESS: begin
                    state <= RESP;
                    if (owner) begin
                        m1.ready <= 1'b1;
                        m1.err   <= err_q;
                        m1.rdata <= rd;
                    end else begin
                        m0.ready <= 1'b1;
                        m0.err   <= err_q;
                        m0.rdata <= rd;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed bench for dmem_arbiter against a byte-array reference model
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wData;
    logic [2:0]  ram_func3;
    logic [31:0] ram_rData;
    logic        mem_init;
    logic [7:0]  mem [64];
    logic [7:0]  ref_mem [64];
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rd;
        int          we_cnt;
        bit          clash;
        bit          other_kept;
        bit          mem_ok;
    } obs_t;

    dmem_arbiter_if m0_if();
    dmem_arbiter_if m1_if();

    dmem_arbiter #(.MEM_BYTES(64)) dut (
        .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if), .busy(busy),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wData(ram_wData),
        .ram_func3(ram_func3), .ram_rData(ram_rData)
    );

    always #5 clk = ~clk;

    // RAM: combinational extended read, byte-lane write on the clock edge
    logic [5:0]  ra;
    logic [31:0] rword;
    always_comb begin
        ra = ram_addr[5:0];
        rword = {mem[ra + 6'd3], mem[ra + 6'd2], mem[ra + 6'd1], mem[ra]};
        case (ram_func3)
            3'b000:  ram_rData = {{24{rword[7]}}, rword[7:0]};
            3'b001:  ram_rData = {{16{rword[15]}}, rword[15:0]};
            3'b100:  ram_rData = {24'd0, rword[7:0]};
            3'b101:  ram_rData = {16'd0, rword[15:0]};
            default: ram_rData = rword;
        endcase
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i * 37 + 5);
        end else if (ram_we) begin
            mem[ram_addr[5:0]] <= ram_wData[7:0];
            if (ram_func3[1:0] != 2'b00) mem[ram_addr[5:0] + 6'd1] <= ram_wData[15:8];
            if (ram_func3[1:0] == 2'b10) begin
                mem[ram_addr[5:0] + 6'd2] <= ram_wData[23:16];
                mem[ram_addr[5:0] + 6'd3] <= ram_wData[31:24];
            end
        end
    end

    // Reference: legality from the access size and the legal func3 sets, then a byte-array access
    task automatic ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] f3, output logic err, output logic [31:0] rdata);
        int     size;
        bit     legal_f3;
        longint v;
        size = 1 << f3[1:0];
        legal_f3 = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err = !legal_f3 || addr >= 64 || (addr % size) != 0;
        rdata = 32'd0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < size; k++) ref_mem[addr + k] = wdata[8 * k +: 8];
            end else begin
                v = 0;
                for (int k = 0; k < size; k++) v = v | (longint'(ref_mem[addr + k]) << (8 * k));
                if (!f3[2] && size < 4 && v[8 * size - 1]) v = v - (64'sd1 <<< (8 * size));
                rdata = v[31:0];
            end
        end
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f);
        if (p == 0) begin
            m0_if.req = r; m0_if.we = w; m0_if.addr = a; m0_if.wdata = d; m0_if.func3 = f;
        end else begin
            m1_if.req = r; m1_if.we = w; m1_if.addr = a; m1_if.wdata = d; m1_if.func3 = f;
        end
    endtask

    function automatic logic [136:0] all_out();
        return {m0_if.ready, m0_if.err, m0_if.rdata, m1_if.ready, m1_if.err, m1_if.rdata,
                busy, ram_we, ram_addr, ram_wData, ram_func3};
    endfunction

    // Issues one request on port p and records what the DUT did until its ready (10-cycle bound)
    task automatic run_txn(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, output obs_t o, output logic exp_err, output logic [31:0] exp_rd);
        logic [31:0] other_before;
        ref_access(we, addr, wdata, f3, exp_err, exp_rd);
        o.lat = 0; o.err = 1'bx; o.rd = 'x; o.we_cnt = 0; o.clash = 0; o.other_kept = 0; o.mem_ok = 1;
        @(negedge clk);
        other_before = (p == 0) ? m1_if.rdata : m0_if.rdata;
        drive(p, 1'b1, we, addr, wdata, f3);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            o.we_cnt += int'(ram_we);
            if ((p == 0) ? (m1_if.ready | m1_if.err) : (m0_if.ready | m0_if.err)) o.clash = 1;
            if ((p == 0) ? m0_if.ready : m1_if.ready) begin
                o.lat = i;
                break;
            end
        end
        o.err = (p == 0) ? m0_if.err : m1_if.err;
        o.rd = (p == 0) ? m0_if.rdata : m1_if.rdata;
        o.other_kept = ((p == 0) ? m1_if.rdata : m0_if.rdata) === other_before;
        drive(p, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        for (int k = 0; k < 64; k++) if (mem[k] !== ref_mem[k]) o.mem_ok = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_init = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_out() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", all_out());
        end
        reset = 1'b0;
        mem_init = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, ram_we, m0_if.ready, m1_if.ready} !== 4'b0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: busy/we/rdy0/rdy1 got %b want 0000", i, {busy, ram_we, m0_if.ready, m1_if.ready});
            end
        end
    endtask

    task automatic test_word();
        obs_t        o;
        logic        e;
        logic [31:0] r;
        run_txn(0, 1'b1, 32'h08, 32'hDEADBEEF, 3'b010, o, e, r);
        n_checks += 4;
        if (o.lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", o.lat); end
        if (o.err !== 1'b0) begin n_fail++; $display("FAIL sw_err: got %b want 0", o.err); end
        if (o.we_cnt !== 1) begin n_fail++; $display("FAIL sw_we_cycles: got %0d want 1", o.we_cnt); end
        if (!o.mem_ok) begin n_fail++; $display("FAIL sw_memory: got contents differing from model want match"); end
        run_txn(0, 1'b0, 32'h08, 32'd0, 3'b010, o, e, r);
        n_checks += 3;
        if (o.lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d want 2", o.lat); end
        if (o.rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", o.rd); end
        if (o.we_cnt !== 0) begin n_fail++; $display("FAIL lw_we_cycles: got %0d want 0", o.we_cnt); end
    endtask

    task automatic test_bytes();
        logic        we  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] ad  [5] = '{32'h08, 32'h09, 32'h08, 32'h09, 32'h09};
        logic [31:0] wd  [5] = '{32'h11223344, 32'h000000AA, 32'd0, 32'd0, 32'd0};
        logic [2:0]  f3  [5] = '{3'b010, 3'b000, 3'b010, 3'b000, 3'b100};
        logic [31:0] cst [5] = '{32'd0, 32'd0, 32'h1122AA44, 32'hFFFFFFAA, 32'h000000AA};
        obs_t        o;
        logic        e;
        logic [31:0] r;
        for (int i = 0; i < 5; i++) begin
            run_txn(1, we[i], ad[i], wd[i], f3[i], o, e, r);
            n_checks += 4;
            if (o.lat !== 2) begin n_fail++; $display("FAIL byte%0d_latency: got %0d want 2", i, o.lat); end
            if (o.err !== 1'b0) begin n_fail++; $display("FAIL byte%0d_err: got %b want 0", i, o.err); end
            if (o.rd !== cst[i]) begin n_fail++; $display("FAIL byte%0d_rdata: got %h want %h", i, o.rd, cst[i]); end
            if (!o.other_kept) begin n_fail++; $display("FAIL byte%0d_m0_rdata_held: got changed want held", i); end
        end
    endtask

    task automatic test_errors();
        logic        we [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] ad [5] = '{32'h0A, 32'h05, 32'h40, 32'h08, 32'h08};
        logic [2:0]  f3 [5] = '{3'b010, 3'b001, 3'b010, 3'b110, 3'b100};
        obs_t        o;
        logic        e;
        logic [31:0] r;
        for (int i = 0; i < 5; i++) begin
            run_txn(0, we[i], ad[i], 32'h5A5A5A5A, f3[i], o, e, r);
            n_checks += 6;
            if (o.lat !== 2) begin n_fail++; $display("FAIL err%0d_latency: got %0d want 2", i, o.lat); end
            if (o.err !== 1'b1) begin n_fail++; $display("FAIL err%0d_flag: got %b want 1", i, o.err); end
            if (e !== 1'b1) begin n_fail++; $display("FAIL err%0d_model: got %b want 1", i, e); end
            if (o.rd !== 32'd0) begin n_fail++; $display("FAIL err%0d_rdata: got %h want 0", i, o.rd); end
            if (o.we_cnt !== 0) begin n_fail++; $display("FAIL err%0d_we_cycles: got %0d want 0", i, o.we_cnt); end
            if (!o.mem_ok) begin n_fail++; $display("FAIL err%0d_memory: got changed want unchanged", i); end
        end
    endtask

    task automatic test_reset_mid();
        logic        e;
        logic [31:0] r;
        int          lat;
        ref_access(1'b0, 32'h08, 32'd0, 3'b010, e, r);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h08, 32'd0, 3'b010);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_access: got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (all_out() !== '0) begin n_fail++; $display("FAIL mid_reset_outputs: got %h want 0", all_out()); end
        reset = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (m0_if.ready) begin
                lat = i;
                break;
            end
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        n_checks += 2;
        if (lat !== 2) begin n_fail++; $display("FAIL mid_fresh_latency: got %0d want 2", lat); end
        if ({m0_if.err, m0_if.rdata} !== {1'b0, r}) begin
            n_fail++; $display("FAIL mid_fresh_result: got %b/%h want 0/%h", m0_if.err, m0_if.rdata, r);
        end
    endtask

    task automatic test_contention();
        logic        e0, e1;
        logic [31:0] r0, r1;
        int          t [4];
        int          who [4];
        int          k;
        int          rd_bad;
        bit          both;
        ref_access(1'b0, 32'h08, 32'd0, 3'b010, e0, r0);
        ref_access(1'b0, 32'h09, 32'd0, 3'b100, e1, r1);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h08, 32'd0, 3'b010);
        drive(1, 1'b1, 1'b0, 32'h09, 32'd0, 3'b100);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        k = 0; rd_bad = 0; both = 0;
        for (int c = 1; c <= 30 && k < 4; c++) begin
            @(negedge clk);
            if (m0_if.ready && m1_if.ready) both = 1;
            if (m0_if.ready || m1_if.ready) begin
                t[k] = c;
                who[k] = m1_if.ready ? 1 : 0;
                if (m1_if.ready ? (m1_if.rdata !== r1) : (m0_if.rdata !== r0)) rd_bad++;
                k++;
            end
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        n_checks += 3;
        if (k !== 4) begin n_fail++; $display("FAIL cont_count: got %0d want 4", k); end
        if (both) begin n_fail++; $display("FAIL cont_both_ready: got 1 want 0"); end
        if (rd_bad !== 0) begin n_fail++; $display("FAIL cont_rdata: got %0d bad want 0", rd_bad); end
        for (int i = 0; i < k; i++) begin
            n_checks += 2;
            if (who[i] !== (i % 2)) begin n_fail++; $display("FAIL cont_order%0d: got m%0d want m%0d", i, who[i], i % 2); end
            if (t[i] !== 2 + 3 * i) begin n_fail++; $display("FAIL cont_time%0d: got %0d want %0d", i, t[i], 2 + 3 * i); end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        obs_t        o;
        logic        e;
        logic [31:0] r;
        int          p;
        logic        we;
        logic [31:0] a;
        logic [2:0]  f;
        for (int i = 0; i < 60; i++) begin
            p = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 32'h47));
            f = 3'($urandom_range(0, 7));
            run_txn(p, we, a, $urandom, f, o, e, r);
            n_checks += 7;
            if (o.lat !== 2) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want 2", i, o.lat); end
            if (o.err !== e) begin n_fail++; $display("FAIL rnd%0d_err: got %b want %b (we=%b a=%h f3=%b)", i, o.err, e, we, a, f); end
            if (o.rd !== r) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h want %h (we=%b a=%h f3=%b)", i, o.rd, r, we, a, f); end
            if (o.we_cnt !== int'(we & ~e)) begin n_fail++; $display("FAIL rnd%0d_we_cycles: got %0d want %0d", i, o.we_cnt, int'(we & ~e)); end
            if (o.clash) begin n_fail++; $display("FAIL rnd%0d_other_port_pulse: got 1 want 0", i); end
            if (!o.other_kept) begin n_fail++; $display("FAIL rnd%0d_other_rdata_held: got changed want held", i); end
            if (!o.mem_ok) begin n_fail++; $display("FAIL rnd%0d_memory: got differs want match model", i); end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 37 + 5);
        mem_init = 1'b0;
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        test_reset();
        test_word();
        test_bytes();
        test_errors();
        test_reset_mid();
        test_contention();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
